booth_mul_iter: RTL and testbench

- Iterative radix-4 Booth multiplier. Signed or unsigned WIDTH x WIDTH operands give a 2*WIDTH product.
- Retires DIGITS_PER_CYCLE Booth digits per clock. Uses valid/ready handshakes on input and output.
- Sits in the EXE/MEM multiply path of the CPU core. Replaces the single-digit combinational partial-product coder plus external adder tree with a self-sequenced, flushable unit.

---
 rtl/booth_mul_iter.sv | 121 ++++++++++++
 tb/tb_booth_mul_iter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_iter.sv
`default_nettype none
// =============================================================================
// booth_mul_iter : iterative radix-4 Booth multiplier, signed/unsigned,
//                  DIGITS_PER_CYCLE digits retired per clock, valid/ready I/O.
// Revision: 1.0
// =============================================================================
module booth_mul_iter #(
  parameter int WIDTH            = 32,
  parameter int DIGITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               busy
);

  localparam int NDIG  = (WIDTH + 2) / 2;
  localparam int NITER = (NDIG + DIGITS_PER_CYCLE - 1) / DIGITS_PER_CYCLE;
  localparam int PW    = 2 * WIDTH;
  localparam int YW    = 2 * NITER * DIGITS_PER_CYCLE + 1;
  localparam int CW    = (NITER > 1) ? $clog2(NITER) : 1;
  localparam int SH    = 2 * DIGITS_PER_CYCLE;
  localparam logic [CW-1:0] LAST = CW'(NITER - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_accept;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_mcand;
  logic [YW-1:0]   r_y;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   w_sum;
  logic            w_xs;
  logic            w_ys;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (r_state != IDLE);
    unique case (r_state)
      IDLE: in_ready = !flush;
      DONE: begin
        in_ready  = !flush && out_ready;
        out_valid = !flush;
      end
      default: ;
    endcase
    w_accept = in_valid && in_ready;
    unique case (r_state)
      IDLE: if (w_accept) w_next = BUSY;
      BUSY: if (r_cnt == LAST) w_next = DONE;
      DONE: if (out_ready) w_next = w_accept ? BUSY : IDLE;
      default: w_next = IDLE;
    endcase
    if (flush) w_next = IDLE;
  end

  // Each digit j of this cycle sits 2*j bits above the running multiplicand weight.
  always_comb begin : p_sum
    logic [PW-1:0] mag;
    w_sum = r_acc;
    mag   = '0;
    for (int j = 0; j < DIGITS_PER_CYCLE; j++) begin
      unique case (r_y[2*j +: 3])
        3'b001, 3'b010: w_sum = w_sum + (r_mcand << (2*j));
        3'b011:         w_sum = w_sum + (r_mcand << (2*j + 1));
        3'b100: begin
          mag   = r_mcand << (2*j + 1);
          w_sum = w_sum + ~mag + PW'(1);
        end
        3'b101, 3'b110: begin
          mag   = r_mcand << (2*j);
          w_sum = w_sum + ~mag + PW'(1);
        end
        default: ;
      endcase
    end
  end

  assign w_xs = in_signed & in_a[WIDTH-1];
  assign w_ys = in_signed & in_b[WIDTH-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_acc   <= '0;
      r_mcand <= {{WIDTH{w_xs}}, in_a};
      r_y     <= {{(YW-1-WIDTH){w_ys}}, in_b, 1'b0};
      r_cnt   <= '0;
    end else if (r_state == BUSY && !flush) begin
      r_acc   <= w_sum;
      r_mcand <= r_mcand << SH;
      r_y     <= $unsigned($signed(r_y) >>> SH);
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign out_prod = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_iter.sv
`default_nettype none
// =============================================================================
// tb_booth_mul_iter : directed + random scoreboard bench for booth_mul_iter.
// Revision: 1.0
// =============================================================================
module tb_booth_mul_iter;
  localparam int W = 32;

  logic clk = 1'b0, resetn = 1'b1, flush = 1'b0;
  logic in_valid = 1'b0, in_signed = 1'b0, out_ready = 1'b1;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, busy;
  logic [2*W-1:0] out_prod;

  logic v2 = 1'b0, v4 = 1'b0, aux_flush = 1'b0, aux_ordy = 1'b1;
  logic r2, r4, ov2, ov4, b2, b4;
  logic [2*W-1:0] p2, p4;

  int vectors = 0, miscompares = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  booth_mul_iter #(.WIDTH(W), .DIGITS_PER_CYCLE(1)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_prod(out_prod), .busy(busy));

  booth_mul_iter #(.WIDTH(W), .DIGITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .resetn(resetn), .flush(aux_flush), .in_valid(v2), .in_ready(r2),
    .in_signed(in_signed), .in_a(in_a), .in_b(in_b), .out_valid(ov2),
    .out_ready(aux_ordy), .out_prod(p2), .busy(b2));

  booth_mul_iter #(.WIDTH(W), .DIGITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .resetn(resetn), .flush(aux_flush), .in_valid(v4), .in_ready(r4),
    .in_signed(in_signed), .in_a(in_a), .in_b(in_b), .out_valid(ov4),
    .out_ready(aux_ordy), .out_prod(p4), .busy(b4));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // Present operands, wait (bounded) for in_ready, accept on the next edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [63:0] exp);
    int n;
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    check("issue ready", {63'b0, in_ready}, 64'd1);
    sb.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_signed = ~s;
  endtask

  task automatic collect(input string tag, input int exp_lat);
    int lat;
    logic [63:0] exp;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 200);
    check({tag, " valid"}, {63'b0, out_valid}, 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    exp = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    check({tag, " prod"}, out_prod, exp);
  endtask

  task automatic aux_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int exp_lat);
    int lat;
    in_a = a; in_b = b; in_signed = 1'b0;
    if (sel == 2) v2 = 1'b1; else v4 = 1'b1;
    #1;
    check("aux ready", {63'b0, (sel == 2) ? r2 : r4}, 64'd1);
    @(posedge clk); #1;
    v2 = 1'b0; v4 = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end
    while (!((sel == 2) ? ov2 : ov4) && lat < 200);
    check("aux latency", 64'(lat), 64'(exp_lat));
    check("aux prod", (sel == 2) ? p2 : p4, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] held;
    logic        seen;
    logic [31:0] ra, rb;
    logic        rs;

    #2 resetn = 1'b0;
    #1;
    check("rst in_ready", {63'b0, in_ready}, 64'd1);
    check("rst out_valid", {63'b0, out_valid}, 64'd0);
    check("rst out_prod", out_prod, 64'd0);
    check("rst busy", {63'b0, busy}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    issue(32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F);
    collect("u3x5", 17);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
    collect("s-1x-1", 17);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    collect("umax", 17);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    collect("sminsq", 17);
    issue(32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000);
    collect("sminx1", 17);
    @(posedge clk); #1;

    aux_op(2, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080, 9);
    aux_op(4, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080, 5);

    // Flush six cycles into BUSY with a new operand offered.
    issue(32'h11, 32'h22, 1'b0, 64'd0);
    repeat (6) begin @(posedge clk); #1; end
    flush = 1'b1; in_valid = 1'b1; in_a = 32'd9; in_b = 32'd9;
    #1;
    check("flush in_ready", {63'b0, in_ready}, 64'd0);
    check("flush busy", {63'b0, busy}, 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("post-flush busy", {63'b0, busy}, 64'd0);
    sb.delete(sb.size() - 1);
    seen = 1'b0;
    repeat (25) begin @(posedge clk); #1; seen |= out_valid; end
    check("flush no valid", {63'b0, seen}, 64'd0);
    issue(32'd7, 32'd6, 1'b0, 64'd42);
    collect("7x6", 17);
    @(posedge clk); #1;

    // Backpressure in DONE, then release together with a new operand.
    out_ready = 1'b0;
    issue(32'hDEAD_BEEF, 32'h0000_1234, 1'b1, model(32'hDEAD_BEEF, 32'h0000_1234, 1'b1));
    collect("bp first", 17);
    held = out_prod;
    in_valid = 1'b1; in_a = 32'd100; in_b = 32'd200; in_signed = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_prod !== held || in_ready !== 1'b0 || out_valid !== 1'b1) seen = 1'b1;
    end
    check("bp stable", {63'b0, seen}, 64'd0);
    out_ready = 1'b1;
    #1;
    check("bp release ready", {63'b0, in_ready}, 64'd1);
    sb.push_back(64'd20000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect("bp second", 17);

    // Asynchronous reset mid-operation.
    issue(32'd5, 32'd9, 1'b0, 64'd45);
    repeat (3) begin @(posedge clk); end
    #2 resetn = 1'b0;
    #1;
    check("mid rst busy", {63'b0, busy}, 64'd0);
    check("mid rst prod", out_prod, 64'd0);
    check("mid rst valid", {63'b0, out_valid}, 64'd0);
    sb.delete(sb.size() - 1);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      issue(ra, rb, rs, model(ra, rb, rs));
      collect("rand", 17);
    end
    @(posedge clk); #1;
    check("sb empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
